irq_pending_latch: RTL and testbench
====================================

# irq_pending_latch

Upstream feeder for the 4-input priority encoder. Captures rising edges on four synchronous request lines into sticky pending bits, applies a mask, drives the masked pending vector into the encoder, takes back the encoder's index and `none` flag, and offers the winning index on a valid/ready handshake. Accepting a request clears its pending bit.

## Interface
Parameters:
- `LEVEL_MODE`, default 0: 0 = pending set on rising edge of `irq_in[i]`; 1 = pending set every cycle `irq_in[i]` is high.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `irq_in`  in  4  request lines, synchronous to `clk`.
- `mask`  in  4  1 = line masked (still latched, not offered).
- `pend_o`  out  4  `pending & ~mask`, combinational; connects to encoder input `a`.
- `enc_y`  in  3  encoder index; values 0..3 valid.
- `enc_none`  in  1  encoder flag, 1 = no input set.
- `irq_valid`  out  1  offer valid.
- `irq_id`  out  2  offered line index.
- `irq_ready`  in  1  consumer accepts when `irq_valid && irq_ready`.
- `ovf_o`  out  4  sticky per-line overflow: edge arrived while that pending bit was already set.
- `ovf_clr`  in  1  one-cycle pulse, clears all `ovf_o` bits.

## Operation
- Edge detect: `irq_q` registers `irq_in`; `rise = irq_in & ~irq_q`. `irq_q` resets to 0, so a line high at reset release counts as an edge.
- Set source: `set = LEVEL_MODE ? irq_in : rise`.
- `pending[i]`: set when `set[i]`; cleared when a handshake completes with `irq_id == i`. Set and clear on the same bit in the same cycle: set wins, so the new event is not lost.
- `ovf[i]`: set when `set[i] && pending[i]` and no clear of `i` occurs that cycle. `ovf_clr` clears all bits; if a set and `ovf_clr` happen in the same cycle, the set wins.
- `enc_y[2]` is treated as don't-care; the low two bits form the index.
- FSM states:
  - `IDLE`: `irq_valid = 0`. If `enc_none == 0`, latch `irq_id <= enc_y[1:0]` and go to `OFFER`.
  - `OFFER`: `irq_valid = 1` and `irq_id` held stable. On `irq_ready`, clear `pending[irq_id]` and go to `IDLE`.
- Once `irq_valid` is asserted it is never withdrawn. Masking or changes in `irq_in` during `OFFER` do not alter `irq_id`.
- Reset values: `irq_q`, `pending`, and `ovf` = 0; state = `IDLE`; `irq_id` = 0; `irq_valid` = 0; `pend_o` = 0.

## Timing
- An edge sampled at clock edge k sets `pending` after k. `pend_o` and the encoder outputs settle in cycle k+1, the FSM moves to `OFFER` at edge k+1, and `irq_valid` is high from cycle k+2. Latency is 2 cycles from `irq_in` high to `irq_valid`.
- Accept at edge m: the pending bit clears and the FSM returns to `IDLE` after m. The next offer is visible no earlier than cycle m+2, giving one bubble cycle between back-to-back offers.
- `irq_ready` without `irq_valid` is ignored.
- `rst` sampled at edge r: all outputs are at reset values in cycle r+1, including `irq_valid = 0` mid-offer. The pending event is discarded.
- All pending bits masked gives `enc_none = 1`, and the FSM stays in `IDLE`.

## Structure
- Shared package `irq_pkg`:
  - `N_IRQ = 4`, `ID_W = 2`.
  - `typedef enum logic {IDLE, OFFER} irq_state_t`.
- Sub-module `irq_edge_detect`: per-vector register plus rise/level select under `LEVEL_MODE`.
- The encoder is not instantiated inside this block. The bench closes the loop by instantiating the existing 4x2 priority encoder between `pend_o` and `enc_y`/`enc_none`.

## Test plan
- Reset, then pulse `irq_in = 4'b0100` for one cycle with `irq_ready = 1`. Required: `irq_valid` goes high 2 cycles later with `irq_id = 2`, accepted the same cycle; `pend_o` returns to 0.
- Set `irq_in = 4'b1010` in one cycle with `irq_ready = 0`. Required: `irq_id` = the encoder's winner (priority order), held until ready; after accept, the other line is offered following one bubble cycle.
- Set `mask = 4'b0001` and pulse line 0. Required: no `irq_valid`, `pending[0] = 1`. Then clear the mask. Required: offered with `irq_id = 0` 1 cycle later.
- Pulse line 3 twice before any accept. Required: `ovf_o = 4'b1000`, a single offer. Then pulse `ovf_clr`. Required: `ovf_o = 0`.
- Pulse line 1 in the same cycle its offer is accepted. Required: `pending[1]` stays 1 and is re-offered after the bubble.
- Assert `rst` while in `OFFER`. Required: `irq_valid = 0`, `pend_o = 0`, `ovf_o = 0` next cycle. With `irq_in` held high through reset release, an offer appears 2 cycles after release.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types for the interrupt pending latch: line count, index width,
// offer FSM state encoding and a one-hot decode helper.
// No ports; imported by the interface, the edge detector and the top.
package irq_pkg;

  localparam int N_IRQ = 4;
  localparam int ID_W  = 2;

  typedef logic [N_IRQ-1:0] irq_vec_t;
  typedef logic [ID_W-1:0]  irq_id_t;

  typedef enum logic {
    IDLE,
    OFFER
  } irq_state_t;

  // One-hot vector selecting a single line by index.
  function automatic irq_vec_t id_onehot(input irq_id_t id);
    irq_vec_t v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/irq_pending_latch_if.sv
// Bundle between the pending latch, the external priority encoder and the
// interrupt consumer. master = latch side, slave = encoder/consumer side.
// Signals: irq_in/mask/ovf_clr (controls), pend_o/enc_y/enc_none (encoder
// loop), irq_valid/irq_id/irq_ready (offer handshake), ovf_o (overflow).
interface irq_pending_latch_if;
  import irq_pkg::*;

  irq_vec_t        irq_in;
  irq_vec_t        mask;
  irq_vec_t        pend_o;
  logic [ID_W:0]   enc_y;
  logic            enc_none;
  logic            irq_valid;
  irq_id_t         irq_id;
  logic            irq_ready;
  irq_vec_t        ovf_o;
  logic            ovf_clr;

  modport master (
    input  irq_in,
    input  mask,
    output pend_o,
    input  enc_y,
    input  enc_none,
    output irq_valid,
    output irq_id,
    input  irq_ready,
    output ovf_o,
    input  ovf_clr
  );

  modport slave (
    output irq_in,
    output mask,
    input  pend_o,
    output enc_y,
    output enc_none,
    input  irq_valid,
    input  irq_id,
    output irq_ready,
    input  ovf_o,
    output ovf_clr
  );

endinterface

// File: rtl/irq_pending_latch_edge_detect.sv
// Per-line event source: registers the request lines and produces either a
// rising-edge pulse or the raw level, selected by LEVEL_MODE.
// Ports: clk, rst (sync, active-high), irq_in (lines), set (event vector,
// combinational from irq_in and the registered copy).
module irq_edge_detect
  import irq_pkg::*;
#(
  parameter bit LEVEL_MODE = 1'b0
) (
  input  logic     clk,
  input  logic     rst,
  input  irq_vec_t irq_in,
  output irq_vec_t set
);

  irq_vec_t irq_q;

  // irq_q clears on reset, so a line already high at reset release is seen
  // as a fresh edge on the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= '0;
    end else begin
      irq_q <= irq_in;
    end
  end

  assign set = LEVEL_MODE ? irq_in : (irq_in & ~irq_q);

endmodule

// File: rtl/irq_pending_latch.sv
// Sticky pending latch feeding an external 4x2 priority encoder; the winner
// is offered on a valid/ready handshake. Latency 2 cycles from request to
// irq_valid; an offer is held until irq_ready, with one bubble between offers.
// Ports: clk, rst (sync, active-high), bus (master side of the interface).
module irq_pending_latch
  import irq_pkg::*;
#(
  parameter bit LEVEL_MODE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  irq_pending_latch_if.master   bus
);

  irq_vec_t   set;
  irq_vec_t   pending;
  irq_vec_t   ovf;
  irq_vec_t   clr;
  irq_vec_t   ovf_set;
  irq_state_t state;
  logic       irq_valid_q;
  irq_id_t    irq_id_q;
  logic       accept;

  // The encoder's top index bit carries no information for four lines.
  logic       unused_enc_hi;
  assign unused_enc_hi = bus.enc_y[ID_W];

  irq_edge_detect #(
    .LEVEL_MODE (LEVEL_MODE)
  ) u_edge (
    .clk    (clk),
    .rst    (rst),
    .irq_in (bus.irq_in),
    .set    (set)
  );

  assign accept = irq_valid_q && bus.irq_ready;
  assign clr    = accept ? id_onehot(irq_id_q) : '0;

  // An event colliding with its own accept is a new event, not an overflow.
  assign ovf_set = set & pending & ~clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      ovf     <= '0;
    end else begin
      // Set is ORed in after the clear so a same-cycle event survives.
      pending <= (pending & ~clr) | set;
      ovf     <= (bus.ovf_clr ? '0 : ovf) | ovf_set;
    end
  end

  // Offer FSM. irq_id is captured on entry to OFFER and frozen there, so
  // mask or request changes during an offer cannot retarget it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.enc_none) begin
            irq_id_q    <= bus.enc_y[ID_W-1:0];
            irq_valid_q <= 1'b1;
            state       <= OFFER;
          end
        end
        OFFER: begin
          if (bus.irq_ready) begin
            irq_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          irq_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.pend_o    = pending & ~bus.mask;
  assign bus.irq_valid = irq_valid_q;
  assign bus.irq_id    = irq_id_q;
  assign bus.ovf_o     = ovf;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch with a behavioural 4x2 priority
// encoder (highest index wins) closing the pend_o -> enc_y loop.
// Expected offer ids are queued at stimulus time and checked at each accept.
module tb_irq_pending_latch;
  import irq_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   n_acc;
  int   exp_q[$];
  event pre_edge;

  irq_pending_latch_if bus ();

  irq_pending_latch #(
    .LEVEL_MODE (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample point just ahead of each rising edge, used for handshake checks.
  always @(negedge clk) begin
    #4;
    -> pre_edge;
  end

  // Priority encoder: highest set index wins; none when input is zero.
  always_comb begin
    bus.enc_y    = 3'd0;
    bus.enc_none = 1'b1;
    if (bus.pend_o[3]) begin
      bus.enc_y = 3'd3; bus.enc_none = 1'b0;
    end else if (bus.pend_o[2]) begin
      bus.enc_y = 3'd2; bus.enc_none = 1'b0;
    end else if (bus.pend_o[1]) begin
      bus.enc_y = 3'd1; bus.enc_none = 1'b0;
    end else if (bus.pend_o[0]) begin
      bus.enc_y = 3'd0; bus.enc_none = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard check before the edge, return at the next negedge.
  task automatic cyc();
    int e;
    @(pre_edge);
    if (bus.irq_valid && bus.irq_ready) begin
      n_acc++;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_accept_qsize", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_accept_id", bus.irq_id, e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0; n_acc = 0;
    rst = 1'b1;
    bus.irq_in = '0; bus.mask = '0; bus.irq_ready = 1'b0; bus.ovf_clr = 1'b0;
    @(negedge clk);
    cyc(); cyc();
    chk("rst_valid", bus.irq_valid, 0);
    chk("rst_id", bus.irq_id, 0);
    chk("rst_pend", bus.pend_o, 0);
    chk("rst_ovf", bus.ovf_o, 0);

    // Single pulse, ready held high: offer 2 cycles later, accepted at once.
    rst = 1'b0; bus.irq_in = 4'b0100; bus.irq_ready = 1'b1; exp_q.push_back(2);
    cyc(); bus.irq_in = '0;
    chk("t1_pend", bus.pend_o, 4'b0100);
    chk("t1_valid_early", bus.irq_valid, 0);
    cyc();
    chk("t1_valid", bus.irq_valid, 1);
    chk("t1_id", bus.irq_id, 2);
    cyc();
    chk("t1_valid_after", bus.irq_valid, 0);
    chk("t1_pend_after", bus.pend_o, 0);

    // Two lines at once: priority winner held, other follows after a bubble.
    bus.irq_ready = 1'b0; bus.irq_in = 4'b1010; exp_q.push_back(3); exp_q.push_back(1);
    cyc(); bus.irq_in = '0;
    cyc();
    chk("t2_valid", bus.irq_valid, 1);
    chk("t2_id", bus.irq_id, 3);
    cyc(); cyc();
    chk("t2_hold_valid", bus.irq_valid, 1);
    chk("t2_hold_id", bus.irq_id, 3);
    bus.irq_ready = 1'b1;
    cyc(); bus.irq_ready = 1'b0;
    chk("t2_bubble", bus.irq_valid, 0);
    chk("t2_pend_left", bus.pend_o, 4'b0010);
    cyc();
    chk("t2_second_valid", bus.irq_valid, 1);
    chk("t2_second_id", bus.irq_id, 1);
    bus.irq_ready = 1'b1;
    cyc(); bus.irq_ready = 1'b0;
    chk("t2_pend_empty", bus.pend_o, 0);
    chk("t2_valid_after", bus.irq_valid, 0);

    // Masked line latches but is not offered until unmasked.
    bus.mask = 4'b0001; bus.irq_in = 4'b0001; exp_q.push_back(0);
    cyc(); bus.irq_in = '0;
    cyc(); cyc();
    chk("t3_masked_valid", bus.irq_valid, 0);
    chk("t3_masked_pend_o", bus.pend_o, 0);
    chk("t3_pending_bit", dut.pending[0], 1);
    bus.mask = '0;
    cyc();
    chk("t3_unmask_valid", bus.irq_valid, 1);
    chk("t3_unmask_id", bus.irq_id, 0);
    bus.irq_ready = 1'b1;
    cyc(); bus.irq_ready = 1'b0;

    // Double pulse before accept: overflow, single offer, then clear.
    bus.irq_in = 4'b1000; exp_q.push_back(3);
    cyc(); bus.irq_in = '0;
    cyc(); bus.irq_in = 4'b1000;
    cyc(); bus.irq_in = '0;
    chk("t4_ovf", bus.ovf_o, 4'b1000);
    chk("t4_valid", bus.irq_valid, 1);
    chk("t4_id", bus.irq_id, 3);
    bus.irq_ready = 1'b1;
    cyc(); bus.irq_ready = 1'b0;
    cyc(); cyc();
    chk("t4_single_offer", bus.irq_valid, 0);
    chk("t4_pend_clear", bus.pend_o, 0);
    chk("t4_ovf_sticky", bus.ovf_o, 4'b1000);
    bus.ovf_clr = 1'b1;
    cyc(); bus.ovf_clr = 1'b0;
    chk("t4_ovf_cleared", bus.ovf_o, 0);

    // Overflow set coinciding with ovf_clr: the set wins.
    bus.irq_in = 4'b0100; exp_q.push_back(2);
    cyc(); bus.irq_in = '0;
    cyc(); bus.irq_in = 4'b0100; bus.ovf_clr = 1'b1;
    cyc(); bus.irq_in = '0; bus.ovf_clr = 1'b0;
    chk("t4_ovf_set_wins", bus.ovf_o, 4'b0100);
    bus.ovf_clr = 1'b1;
    cyc(); bus.ovf_clr = 1'b0;
    chk("t4_ovf_cleared2", bus.ovf_o, 0);
    bus.irq_ready = 1'b1;
    cyc(); bus.irq_ready = 1'b0;
    chk("t4_valid_after", bus.irq_valid, 0);

    // New edge on the line being accepted: pending survives, re-offered.
    bus.irq_in = 4'b0010; exp_q.push_back(1);
    cyc(); bus.irq_in = '0;
    cyc();
    chk("t5_valid", bus.irq_valid, 1);
    chk("t5_id", bus.irq_id, 1);
    bus.irq_in = 4'b0010; bus.irq_ready = 1'b1; exp_q.push_back(1);
    cyc(); bus.irq_in = '0; bus.irq_ready = 1'b0;
    chk("t5_bubble", bus.irq_valid, 0);
    chk("t5_pend_kept", bus.pend_o, 4'b0010);
    chk("t5_no_ovf", bus.ovf_o, 0);
    cyc();
    chk("t5_reoffer_valid", bus.irq_valid, 1);
    chk("t5_reoffer_id", bus.irq_id, 1);
    bus.irq_ready = 1'b1;
    cyc(); bus.irq_ready = 1'b0;
    chk("t5_pend_empty", bus.pend_o, 0);

    // Reset mid-offer discards everything; a held line re-offers after release.
    bus.irq_in = 4'b0100;
    cyc(); bus.irq_in = '0;
    cyc(); bus.irq_in = 4'b0100;
    cyc();
    chk("t6_pre_valid", bus.irq_valid, 1);
    chk("t6_pre_ovf", bus.ovf_o, 4'b0100);
    bus.irq_in = 4'b0001; rst = 1'b1;
    cyc();
    chk("t6_rst_valid", bus.irq_valid, 0);
    chk("t6_rst_pend", bus.pend_o, 0);
    chk("t6_rst_ovf", bus.ovf_o, 0);
    chk("t6_rst_id", bus.irq_id, 0);
    rst = 1'b0; exp_q.push_back(0);
    cyc();
    chk("t6_rel_valid", bus.irq_valid, 0);
    chk("t6_rel_pend", bus.pend_o, 4'b0001);
    cyc();
    chk("t6_offer_valid", bus.irq_valid, 1);
    chk("t6_offer_id", bus.irq_id, 0);
    bus.irq_ready = 1'b1;
    cyc(); bus.irq_ready = 1'b0; bus.irq_in = '0;
    cyc();
    chk("t6_valid_after", bus.irq_valid, 0);

    chk("sb_left_over", exp_q.size(), 0);
    chk("accept_count", n_acc, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
